// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and the IF/ID field bundle carried through the
// IF/ID skid stage.
package riscv_pkg;

    localparam int OPCODE_W     = 7;
    localparam int FUNCT7_W     = 7;
    localparam int FUNCT3_W     = 3;
    localparam int REG_W        = 5;
    localparam int XLEN_DEFAULT = 64;

    // imm/pc are sized for the widest supported XLEN; narrower builds zero-extend.
    typedef struct packed {
        logic [OPCODE_W-1:0]     opcode;
        logic [FUNCT7_W-1:0]     funct7;
        logic [FUNCT3_W-1:0]     funct3;
        logic [REG_W-1:0]        rd;
        logic [REG_W-1:0]        rs1;
        logic [REG_W-1:0]        rs2;
        logic [XLEN_DEFAULT-1:0] imm;
        logic [XLEN_DEFAULT-1:0] pc;
    } ifid_fields_t;

    localparam int IFID_FIELDS_W = $bits(ifid_fields_t);

endpackage

// File: rtl/ifid_skid_stage_if.sv
// IF/ID stage bus: upstream handshake, decoded fields, downstream handshake,
// flush and performance counters.
interface ifid_skid_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) ();

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] opcode_in;
    logic [FUNCT7_W-1:0] funct7_in;
    logic [FUNCT3_W-1:0] funct3_in;
    logic [REG_W-1:0]    rd_in;
    logic [REG_W-1:0]    rs1_in;
    logic [REG_W-1:0]    rs2_in;
    logic [XLEN-1:0]     imm_in;
    logic [XLEN-1:0]     pc_in;

    logic                out_valid;
    logic                out_ready;
    logic [OPCODE_W-1:0] opcode_out;
    logic [FUNCT7_W-1:0] funct7_out;
    logic [FUNCT3_W-1:0] funct3_out;
    logic [REG_W-1:0]    rd_out;
    logic [REG_W-1:0]    rs1_out;
    logic [REG_W-1:0]    rs2_out;
    logic [XLEN-1:0]     imm_out;
    logic [XLEN-1:0]     pc_out;

    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    bubble_cnt;

    modport master (
        output flush, in_valid, opcode_in, funct7_in, funct3_in,
               rd_in, rs1_in, rs2_in, imm_in, pc_in, out_ready,
        input  in_ready, out_valid, opcode_out, funct7_out, funct3_out,
               rd_out, rs1_out, rs2_out, imm_out, pc_out,
               stall_cnt, bubble_cnt
    );

    modport slave (
        input  flush, in_valid, opcode_in, funct7_in, funct3_in,
               rd_in, rs1_in, rs2_in, imm_in, pc_in, out_ready,
        output in_ready, out_valid, opcode_out, funct7_out, funct3_out,
               rd_out, rs1_out, rs2_out, imm_out, pc_out,
               stall_cnt, bubble_cnt
    );

endinterface

// File: rtl/ifid_skid_stage_skid_buf.sv
// skid_buf: generic two-entry valid/ready skid buffer with synchronous flush.
// Main entry drives the output; skid entry catches a word while main is held.
module skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;

    logic              w_m_valid_next;
    logic [DATA_W-1:0] w_m_data_next;
    logic              w_s_valid_next;
    logic [DATA_W-1:0] w_s_data_next;

    logic              w_in_acc;
    logic              w_out_hs;

    assign w_in_acc = i_valid && !r_s_valid;
    assign w_out_hs = r_m_valid && i_ready;

    always_comb begin
        w_m_valid_next = r_m_valid;
        w_m_data_next  = r_m_data;
        w_s_valid_next = r_s_valid;
        w_s_data_next  = r_s_data;

        // Flush only clears valid bits; payloads keep their last value.
        if (i_flush) begin
            w_m_valid_next = 1'b0;
            w_s_valid_next = 1'b0;
        end else if (!r_m_valid || w_out_hs) begin
            if (r_s_valid) begin
                w_m_valid_next = 1'b1;
                w_m_data_next  = r_s_data;
                w_s_valid_next = w_in_acc;
                if (w_in_acc) begin
                    w_s_data_next = i_data;
                end
            end else if (w_in_acc) begin
                w_m_valid_next = 1'b1;
                w_m_data_next  = i_data;
            end else begin
                w_m_valid_next = 1'b0;
            end
        end else if (w_in_acc) begin
            w_s_valid_next = 1'b1;
            w_s_data_next  = i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else begin
            r_m_valid <= w_m_valid_next;
            r_m_data  <= w_m_data_next;
            r_s_valid <= w_s_valid_next;
            r_s_data  <= w_s_data_next;
        end
    end

    // Ready depends only on the skid register, never on i_ready or i_flush.
    assign o_ready = !r_s_valid;
    assign o_valid = r_m_valid;
    assign o_data  = r_m_data;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage: decoded fields through a two-entry skid buffer with flush.
// Define IFID_PERF_CNT_EN to build the stall/bubble performance counters.
module ifid_skid_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    ifid_skid_stage_if.slave   bus
);

    ifid_fields_t w_in_fields;
    ifid_fields_t w_out_fields;
    logic         w_out_valid;
    logic         w_in_ready;

    always_comb begin
        w_in_fields        = '0;
        w_in_fields.opcode = bus.opcode_in;
        w_in_fields.funct7 = bus.funct7_in;
        w_in_fields.funct3 = bus.funct3_in;
        w_in_fields.rd     = bus.rd_in;
        w_in_fields.rs1    = bus.rs1_in;
        w_in_fields.rs2    = bus.rs2_in;
        w_in_fields.imm    = XLEN_DEFAULT'(bus.imm_in);
        w_in_fields.pc     = XLEN_DEFAULT'(bus.pc_in);
    end

    skid_buf #(
        .DATA_W (IFID_FIELDS_W)
    ) u_skid_buf (
        .clk     (clk),
        .reset   (reset),
        .i_flush (bus.flush),
        .i_valid (bus.in_valid),
        .o_ready (w_in_ready),
        .i_data  (w_in_fields),
        .o_valid (w_out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out_fields)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.opcode_out = w_out_fields.opcode;
    assign bus.funct7_out = w_out_fields.funct7;
    assign bus.funct3_out = w_out_fields.funct3;
    assign bus.rd_out     = w_out_fields.rd;
    assign bus.rs1_out    = w_out_fields.rs1;
    assign bus.rs2_out    = w_out_fields.rs2;
    assign bus.imm_out    = w_out_fields.imm[XLEN-1:0];
    assign bus.pc_out     = w_out_fields.pc[XLEN-1:0];

`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!w_out_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.bubble_cnt = r_bubble_cnt;
`else
    assign bus.stall_cnt  = '0;
    assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench for ifid_skid_stage: streaming, backpressure, flush, async reset
// and counter saturation with a 4-bit counter build.
module tb_ifid_skid_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ifid_skid_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    ifid_skid_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] cnt_exp(input logic [63:0] v);
`ifdef IFID_PERF_CNT_EN
        return v;
`else
        return 64'd0 & v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode_in = 7'h33;
        bus.funct7_in = 7'h20;
        bus.funct3_in = 3'h5;
        bus.rd_in     = 5'd3;
        bus.rs1_in    = 5'd4;
        bus.rs2_in    = 5'd5;
        bus.imm_in    = 64'hFFFF_FFFF_FFFF_FFF0;
        bus.pc_in     = 64'h0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        $display("reset released");
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_opcode", 64'(bus.opcode_out), 64'd0);
        chk("rst_rd", 64'(bus.rd_out), 64'd0);
        chk("rst_imm", bus.imm_out, 64'd0);
        chk("rst_pc", bus.pc_out, 64'd0);
        chk("rst_stall", 64'(bus.stall_cnt), 64'd0);

        repeat (3) step();
        $display("idle 3 cycles");
        chk("idle_bubble", 64'(bus.bubble_cnt), cnt_exp(64'd3));
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Stream 0x0, 0x4, 0x8 with downstream always ready.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_in = 64'(i * 4);
            step();
            $display("stream pc=%0h out_pc=%0h", i * 4, bus.pc_out);
            chk("stream_valid", 64'(bus.out_valid), 64'd1);
            chk("stream_pc", bus.pc_out, 64'(i * 4));
            chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
        end
        chk("stream_opcode", 64'(bus.opcode_out), 64'h33);
        chk("stream_funct7", 64'(bus.funct7_out), 64'h20);
        chk("stream_funct3", 64'(bus.funct3_out), 64'h5);
        chk("stream_rs1", 64'(bus.rs1_out), 64'd4);
        chk("stream_rs2", 64'(bus.rs2_out), 64'd5);
        chk("stream_imm", bus.imm_out, 64'hFFFF_FFFF_FFFF_FFF0);
        bus.in_valid = 1'b0;
        step();
        $display("stream drained");
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_bubble", 64'(bus.bubble_cnt), cnt_exp(64'd4));
        chk("drain_stall", 64'(bus.stall_cnt), 64'd0);

        // Backpressure: 0x10 held in M, 0x14 lands in S.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.pc_in     = 64'h10;
        step();
        $display("bp send 0x10");
        chk("bp_m_pc", bus.pc_out, 64'h10);
        chk("bp_m_in_ready", 64'(bus.in_ready), 64'd1);
        bus.pc_in = 64'h14;
        step();
        $display("bp send 0x14");
        chk("bp_s_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_s_pc_held", bus.pc_out, 64'h10);
        bus.in_valid = 1'b0;
        step();
        chk("bp_hold_pc", bus.pc_out, 64'h10);
        bus.out_ready = 1'b1;
        step();
        $display("bp release, out_pc=%0h", bus.pc_out);
        chk("bp_rel_pc", bus.pc_out, 64'h14);
        chk("bp_rel_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_rel_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp_done_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_stall", 64'(bus.stall_cnt), cnt_exp(64'd2));
        chk("bp_bubble", 64'(bus.bubble_cnt), cnt_exp(64'd5));

        // Flush with both entries full and an input offered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.pc_in     = 64'h20;
        step();
        bus.pc_in = 64'h24;
        step();
        chk("fl_full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.flush = 1'b1;
        bus.pc_in = 64'h18;
        step();
        $display("flush with both entries full");
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        chk("fl_pc_hold", bus.pc_out, 64'h20);
        bus.pc_in = 64'h28;
        step();
        $display("flush with input accepted");
        chk("fl2_out_valid", 64'(bus.out_valid), 64'd0);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("fl_after_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_after_pc", bus.pc_out, 64'h20);
        chk("fl_stall", 64'(bus.stall_cnt), cnt_exp(64'd4));
        chk("fl_bubble", 64'(bus.bubble_cnt), cnt_exp(64'd8));

        // Asynchronous reset between edges.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.pc_in     = 64'h30;
        step();
        chk("ar_pre_pc", bus.pc_out, 64'h30);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        $display("async reset mid-cycle");
        chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_pc", bus.pc_out, 64'd0);
        chk("ar_imm", bus.imm_out, 64'd0);
        chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
        chk("ar_stall", 64'(bus.stall_cnt), 64'd0);
        chk("ar_bubble", 64'(bus.bubble_cnt), 64'd0);
        #1;
        reset = 1'b0;

        // Stall counter saturation at 15 with CNT_W=4.
        bus.in_valid = 1'b1;
        bus.pc_in    = 64'h40;
        step();
        bus.in_valid = 1'b0;
        chk("sat_pc", bus.pc_out, 64'h40);
        repeat (10) step();
        $display("stall 10 cycles");
        chk("sat_stall10", 64'(bus.stall_cnt), cnt_exp(64'd10));
        repeat (10) step();
        $display("stall 20 cycles");
        chk("sat_stall20", 64'(bus.stall_cnt), cnt_exp(64'd15));
        chk("sat_bubble", 64'(bus.bubble_cnt), cnt_exp(64'd1));
        chk("sat_valid", 64'(bus.out_valid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifid_skid_stage.md
# ifid_skid_stage

Parametrised IF/ID pipeline stage that carries decoded instruction fields (opcode, register indices, funct fields, immediate, PC) from fetch/decode into execute under a valid/ready handshake. A two-entry skid buffer gives full throughput with a fully registered `in_ready`. A synchronous flush squashes in-flight instructions on branch redirect. It replaces the plain always-load IF/ID register: it adds backpressure, flush, and defined reset values.

## Interface
- `XLEN`, default 64: width of `imm` and `pc`.
- `CNT_W`, default 32: width of the performance counters.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `flush`  in  1: synchronous squash of all held entries.
- `in_valid`  in  1: upstream holds a valid instruction.
- `in_ready`  out  1: stage can accept; driven from registers only.
- `opcode_in`  in  7, `funct7_in`  in  7, `funct3_in`  in  3: decoded fields.
- `rd_in`, `rs1_in`, `rs2_in`  in  5 each: register indices.
- `imm_in`, `pc_in`  in  XLEN each: immediate and instruction PC.
- `out_valid`  out  1: the output fields hold a valid instruction.
- `out_ready`  in  1: downstream accepts.
- `opcode_out`, `funct7_out`, `funct3_out`, `rd_out`, `rs1_out`, `rs2_out`, `imm_out`, `pc_out`  out: same widths as the matching inputs.
- `stall_cnt`  out  CNT_W: count of backpressure cycles.
- `bubble_cnt`  out  CNT_W: count of empty-output cycles.

## Operation
- Storage is two entries:
  - main (M): drives the outputs.
  - skid (S): used only when M is held and a new word arrives.
- Input accept occurs when `in_valid && in_ready`. Output handoff occurs when `out_valid && out_ready`.
- `in_ready = !S.valid`. `out_valid = M.valid`.
- Each cycle without flush:
  - If M is empty, or M is handed off this cycle: M loads S when S is valid; otherwise M loads the accepted input; otherwise M goes empty.
  - If S was valid and moved to M, and an input is accepted the same cycle, the input loads S.
  - If M is held (valid and not handed off) and an input is accepted, the input loads S.
- Order is strictly FIFO. No entry is duplicated or dropped, except on flush.
- Flush has priority over every other event:
  - Next cycle, M.valid and S.valid are 0.
  - An input accepted in the flush cycle is discarded.
  - A handoff in the flush cycle still counts as completed downstream.
- Data fields of an invalid entry hold their last value. Only the valid bits are cleared.
- Reset values:
  - `out_valid=0`, `in_ready=1`.
  - All field outputs are 0, including `pc_out`.
  - Both counters are 0.
- `reset` asserted mid-operation discards both entries immediately (asynchronous).
- Counters increment by 1 per cycle and saturate at all-ones:
  - `stall_cnt` increments when `out_valid && !out_ready`.
  - `bubble_cnt` increments when `!out_valid`.
  - Flush does not clear the counters.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on the outputs after edge N when M was empty.
- Throughput is 1 instruction/cycle while `out_ready` stays high.
- `in_ready` falls the cycle after a word enters S. It rises the cycle after S drains.
- There is no combinational path from `out_ready` or `flush` to `in_ready`.

## Configuration
- `IFID_PERF_CNT_EN` defined: both counters are implemented as specified.
- `IFID_PERF_CNT_EN` undefined: counter logic is removed. `stall_cnt` and `bubble_cnt` are tied to 0, and the ports remain so instantiations are unchanged.

## Structure
- Shared package `riscv_pkg` holds:
  - the opcode/funct/reg-index width constants (7/7/3/5);
  - the `XLEN` default;
  - a packed `ifid_fields_t` struct bundling all carried fields, used for M and S storage.
- One natural sub-module, `skid_buf`: generic 2-entry valid/ready skid buffer over a `DATA_W` payload, with flush. `ifid_skid_stage` packs the fields into `ifid_fields_t`, instantiates `skid_buf`, and adds the counters.

## Test plan
- Reset, then idle for 3 cycles: all outputs are 0, `in_ready=1`, `out_valid=0`, and with the macro `bubble_cnt=3`.
- Stream pc 0x0,0x4,0x8 with `out_ready=1`: outputs appear one cycle later in order, with no gaps.
- `out_ready=0` while sending pc 0x10,0x14: 0x10 held in M, 0x14 in S, `in_ready=0` the next cycle. Raise `out_ready`: 0x10 then 0x14 are output, and `in_ready` returns to 1.
- Both entries full and `flush=1` with `in_valid=1` (pc 0x18): next cycle `out_valid=0` and `in_ready=1`, and 0x18 never appears.
- Assert `reset` asynchronously mid-stream (between edges): outputs go to 0 immediately and the counters clear.
- With `CNT_W=4`, hold `out_valid=1` and `out_ready=0` for 20 cycles: `stall_cnt` saturates at 15. With the macro undefined, it stays 0.
